// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, bridge state encoding and response helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // Anything other than a plain OKAY is reported to the core as an error.
  function automatic logic is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Response-wait counter: clear, enable, and a combinational expiry flag on the last allowed cycle.
module axi_lite_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // A zero TIMEOUT disables expiry entirely.
  assign expire_c = (TIMEOUT != 0) && en_i && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/axi_lite_io_bridge.sv
// Single-request MMIO to AXI4-Lite master bridge with base offset, error reporting and hang timeout.
module axi_lite_io_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        TIMEOUT   = 1024,
  localparam int unsigned       STRB_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic              bready_q, bready_d, rready_q, rready_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              req_ready_q, req_ready_d;
  logic              wait_c, expire_c;

  assign wait_c = (state_q == ST_WRESP) || (state_q == ST_RDATA);

  axi_lite_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!wait_c),
    .en_i     (wait_c),
    .expire_c (expire_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr + BASE_ADDR;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        // Both channels already dropped their valids: move on a cycle later.
        if (!awvalid_q && !wvalid_q) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (m_axi_bvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = is_err(m_axi_bresp);
          bready_d     = 1'b0;
          state_d      = ST_IDLE;
        end else if (expire_c) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = ST_DRAIN;
        end
      end
      ST_RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi_rvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = is_err(m_axi_rresp);
          resp_rdata_d = m_axi_rdata;
          rready_d     = 1'b0;
          state_d      = ST_IDLE;
        end else if (expire_c) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The late response is swallowed without a completion pulse.
        if (we_q ? m_axi_bvalid : m_axi_rvalid) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_io_bridge.sv
// Directed bench for axi_lite_io_bridge: write/read timing, stalls, errors, timeout drain, async reset.
module tb_axi_lite_io_bridge;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [1:0] bresp, rresp;

  int errors = 0;
  int checks = 0;
  int b_hs = 0, r_hs = 0, resp_cnt = 0;
  int b0, r0, q0, n;

  always #5 clk = ~clk;

  axi_lite_io_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(32'h1000_0000), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Handshake and completion counters.
  always @(posedge clk) begin
    if (rst) begin
      if (bvalid && bready) b_hs <= b_hs + 1;
      if (rvalid && rready) r_hs <= r_hs + 1;
      if (resp_valid)       resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic request(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    repeat (2) cyc();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk32("rst_awaddr", awaddr, 32'h0);
    rst = 1'b1;
    cyc();

    // Best-case write: slave always ready.
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    request(1'b1, 32'h8, 32'hDEAD_BEEF);
    cyc();
    req_valid = 0;
    chk1("w1_awvalid", awvalid, 1'b1);
    chk1("w1_wvalid", wvalid, 1'b1);
    chk32("w1_awaddr", awaddr, 32'h1000_0008);
    chk32("w1_wdata", wdata, 32'hDEAD_BEEF);
    chk32("w1_wstrb", 32'(wstrb), 32'hF);
    chk1("w1_req_ready_busy", req_ready, 1'b0);
    cyc();
    chk1("w1_awvalid_drop", awvalid, 1'b0);
    chk1("w1_wvalid_drop", wvalid, 1'b0);
    chk1("w1_no_early_resp", resp_valid, 1'b0);
    cyc();
    chk1("w1_bready", bready, 1'b1);
    chk1("w1_no_resp_c3", resp_valid, 1'b0);
    cyc();
    chk1("w1_resp_valid_c4", resp_valid, 1'b1);
    chk1("w1_resp_err", resp_err, 1'b0);
    chk1("w1_req_ready_back", req_ready, 1'b1);
    chk1("w1_bready_off", bready, 1'b0);
    cyc();
    chk1("w1_resp_pulse", resp_valid, 1'b0);

    // Write with awready late, wready immediate.
    b0 = b_hs; q0 = resp_cnt;
    awready = 0; wready = 1; bvalid = 1; bresp = 2'b00;
    request(1'b1, 32'h10, 32'hA5A5_A5A5);
    cyc();
    req_valid = 0;
    chk1("w2_awvalid_c1", awvalid, 1'b1);
    chk1("w2_wvalid_c1", wvalid, 1'b1);
    for (int c = 2; c <= 3; c++) begin
      cyc();
      chk1("w2_wvalid_dropped", wvalid, 1'b0);
      chk1("w2_awvalid_held", awvalid, 1'b1);
      chk32("w2_awaddr_stable", awaddr, 32'h1000_0010);
    end
    cyc();
    chk1("w2_awvalid_c4", awvalid, 1'b1);
    awready = 1;
    cyc();
    awready = 0;
    chk1("w2_awvalid_done", awvalid, 1'b0);
    chk1("w2_no_bready_yet", bready, 1'b0);
    cyc();
    chk1("w2_bready", bready, 1'b1);
    cyc();
    chk1("w2_resp_valid", resp_valid, 1'b1);
    chk1("w2_resp_err", resp_err, 1'b0);
    cyc();
    chk1("w2_resp_pulse", resp_valid, 1'b0);
    chk32("w2_one_b_hs", 32'(b_hs - b0), 32'd1);
    chk32("w2_one_resp", 32'(resp_cnt - q0), 32'd1);

    // Write with wready late, awready immediate; EXOKAY counts as error.
    b0 = b_hs; q0 = resp_cnt;
    awready = 1; wready = 0; bvalid = 1; bresp = 2'b01;
    request(1'b1, 32'h14, 32'h5A5A_5A5A);
    cyc();
    req_valid = 0;
    chk1("w3_awvalid_c1", awvalid, 1'b1);
    chk1("w3_wvalid_c1", wvalid, 1'b1);
    for (int c = 2; c <= 3; c++) begin
      cyc();
      chk1("w3_awvalid_dropped", awvalid, 1'b0);
      chk1("w3_wvalid_held", wvalid, 1'b1);
      chk32("w3_wdata_stable", wdata, 32'h5A5A_5A5A);
    end
    cyc();
    wready = 1;
    cyc();
    wready = 0;
    chk1("w3_wvalid_done", wvalid, 1'b0);
    cyc();
    chk1("w3_bready", bready, 1'b1);
    cyc();
    chk1("w3_resp_valid", resp_valid, 1'b1);
    chk1("w3_resp_err_exokay", resp_err, 1'b1);
    cyc();
    chk32("w3_one_b_hs", 32'(b_hs - b0), 32'd1);
    chk32("w3_one_resp", 32'(resp_cnt - q0), 32'd1);
    bvalid = 0; awready = 0; bresp = 2'b00;

    // Read with arready after 2 cycles, rvalid after 5, SLVERR.
    request(1'b0, 32'h4, 32'h0);
    cyc();
    req_valid = 0;
    chk1("r1_arvalid", arvalid, 1'b1);
    chk32("r1_araddr", araddr, 32'h1000_0004);
    chk1("r1_req_ready", req_ready, 1'b0);
    cyc();
    chk1("r1_arvalid_held", arvalid, 1'b1);
    cyc();
    arready = 1;
    cyc();
    arready = 0;
    chk1("r1_arvalid_done", arvalid, 1'b0);
    chk1("r1_rready", rready, 1'b1);
    for (int c = 5; c <= 8; c++) begin
      cyc();
      chk1("r1_busy", req_ready, 1'b0);
      chk1("r1_no_resp", resp_valid, 1'b0);
    end
    cyc();
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    cyc();
    rvalid = 0;
    chk1("r1_resp_valid", resp_valid, 1'b1);
    chk32("r1_rdata", resp_rdata, 32'h1234_5678);
    chk1("r1_resp_err", resp_err, 1'b1);
    chk1("r1_req_ready_back", req_ready, 1'b1);
    cyc();
    chk1("r1_resp_pulse", resp_valid, 1'b0);
    chk32("r1_rdata_hold", resp_rdata, 32'h1234_5678);

    // Read then write presented in the read's resp_valid cycle.
    r0 = r_hs;
    arready = 1; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    request(1'b0, 32'h20, 32'h0);
    cyc();
    req_valid = 0;
    chk1("bb_arvalid", arvalid, 1'b1);
    cyc();
    chk1("bb_rready", rready, 1'b1);
    cyc();
    chk1("bb_rd_resp", resp_valid, 1'b1);
    chk32("bb_rd_data", resp_rdata, 32'hCAFE_F00D);
    chk1("bb_req_ready", req_ready, 1'b1);
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    request(1'b1, 32'h24, 32'h0BAD_F00D);
    cyc();
    req_valid = 0;
    chk1("bb_wr_accepted", awvalid, 1'b1);
    chk32("bb_awaddr", awaddr, 32'h1000_0024);
    chk1("bb_rready_off", rready, 1'b0);
    cyc();
    cyc();
    cyc();
    chk1("bb_wr_resp", resp_valid, 1'b1);
    chk1("bb_wr_err", resp_err, 1'b0);
    chk32("bb_rdata_kept", resp_rdata, 32'hCAFE_F00D);
    rvalid = 0; bvalid = 0; awready = 0; wready = 0;
    cyc();
    chk32("bb_one_r_hs", 32'(r_hs - r0), 32'd1);

    // Timeout on a read, then a late rvalid is drained silently.
    q0 = resp_cnt;
    arready = 1;
    request(1'b0, 32'h40, 32'h0);
    cyc();
    req_valid = 0;
    chk1("to_arvalid", arvalid, 1'b1);
    n = 1;
    do begin
      cyc();
      n++;
    end while (!resp_valid && n < 40);
    arready = 0;
    chk32("to_latency", 32'(n), 32'd18);
    chk1("to_resp_err", resp_err, 1'b1);
    chk32("to_rdata_zero", resp_rdata, 32'h0);
    chk1("to_req_ready_drain", req_ready, 1'b0);
    chk1("to_rready_drain", rready, 1'b1);
    for (int c = 19; c < 30; c++) begin
      cyc();
      chk1("to_drain_busy", req_ready, 1'b0);
      chk1("to_drain_quiet", resp_valid, 1'b0);
    end
    cyc();
    rvalid = 1; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
    cyc();
    rvalid = 0;
    chk1("to_req_ready_after", req_ready, 1'b1);
    chk1("to_no_second_resp", resp_valid, 1'b0);
    chk1("to_rready_after", rready, 1'b0);
    chk32("to_rdata_not_taken", resp_rdata, 32'h0);
    cyc();
    chk32("to_one_resp", 32'(resp_cnt - q0), 32'd1);

    // Asynchronous reset in the middle of WADDR.
    q0 = resp_cnt;
    request(1'b1, 32'h30, 32'h1111_2222);
    cyc();
    req_valid = 0;
    chk1("ar_awvalid_pre", awvalid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("ar_awvalid_async", awvalid, 1'b0);
    chk1("ar_wvalid_async", wvalid, 1'b0);
    chk1("ar_resp_valid_async", resp_valid, 1'b0);
    chk1("ar_req_ready_async", req_ready, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    chk1("ar_req_ready_post", req_ready, 1'b1);
    chk1("ar_awvalid_post", awvalid, 1'b0);
    arready = 1; rvalid = 1; rdata = 32'h0000_0077; rresp = 2'b00;
    request(1'b0, 32'h0, 32'h0);
    cyc();
    req_valid = 0;
    cyc();
    cyc();
    chk1("ar_read_resp", resp_valid, 1'b1);
    chk32("ar_read_data", resp_rdata, 32'h0000_0077);
    arready = 0; rvalid = 0;
    cyc();
    chk32("ar_resp_count", 32'(resp_cnt - q0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_io_bridge.md
Name: axi_lite_io_bridge

Overview:
- Parametrised AXI4-Lite master that turns the core's single-request MMIO port into AXI4-Lite read/write transactions. Used for UART and future peripherals.
- Sits between the core and the AXI interconnect.
- Beyond a plain pass-through it adds:
  - independent AW/W handshakes;
  - a base-address offset;
  - error reporting from BRESP/RRESP;
  - a bus-hang timeout with response draining.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; must be 32 or 64. STRB_W = DATA_W/8.
- BASE_ADDR, 32'h0, added modulo 2^ADDR_W to req_addr to form AxADDR.
- TIMEOUT, 1024, cycles to wait for B/R after the address/data are accepted. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge accepts request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address, before offset.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  STRB_W  byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid with resp_valid on reads.
- resp_err  out  1  error flag (SLVERR/DECERR or timeout), valid with resp_valid.
- m_axi_awaddr  out  ADDR_W; m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  DATA_W; m_axi_wstrb  out  STRB_W; m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- m_axi_araddr  out  ADDR_W; m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All *valid, bready, rready, resp_valid and resp_err are 0. Address/data/rdata registers are 0. Timeout counter is 0.
- req_ready = (state==IDLE). No resp_valid is issued for any request in flight at reset.
- AXI outputs are registered. A valid is never deasserted before its handshake completes, and payloads are held stable while valid=1.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DRAIN.
- IDLE:
  - On req_valid & req_ready, latch the request and form addr = req_addr + BASE_ADDR.
  - Write -> WADDR, with awvalid=wvalid=1 from the next cycle.
  - Read -> RADDR, with arvalid=1.
- WADDR:
  - awvalid and wvalid drop independently on their own handshakes; either order, or both in the same cycle, is legal.
  - When both are done -> WRESP, bready=1, counter cleared.
- WRESP:
  - On bvalid: resp_valid=1 next cycle, resp_err = (bresp!=2'b00), then -> IDLE.
- RADDR: on arready -> RDATA, rready=1, counter cleared.
- RDATA:
  - On rvalid: resp_rdata=rdata and resp_err=(rresp!=0) are registered, resp_valid=1 next cycle, then -> IDLE.
  - resp_rdata holds its value until the next read completes.
- Timeout:
  - The counter increments each cycle in WRESP/RDATA.
  - When counter==TIMEOUT-1 without bvalid/rvalid: resp_valid=1, resp_err=1, resp_rdata=0, -> DRAIN.
  - bvalid/rvalid arriving in that same cycle wins; that is a normal completion, not a timeout.
  - WADDR/RADDR never time out, because a valid cannot legally be dropped.
- DRAIN:
  - bready/rready stay 1. The late response is consumed silently, with no resp_valid.
  - -> IDLE after it arrives.
  - req_ready=0 throughout.
- Throughput: best case write = 4 cycles from request accept to resp_valid (awready/wready/bvalid all immediate); best case read = 3.
- A new request may be accepted in the same cycle as resp_valid, since state is then IDLE.
- Unexpected bvalid/rvalid outside WRESP/RDATA/DRAIN are ignored; ready stays 0 for them.

Decomposition:
- Package axi_lite_pkg holds:
  - resp codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the state enum;
  - a helper function is_err(resp).
- One natural sub-module: axi_lite_timeout_ctr, a parametrised counter with clear, enable and expiry pulse. Its output is tied low when TIMEOUT=0.

Test Plan:
- Write, slave always ready, req_addr=0x8, BASE_ADDR=0x1000_0000, wdata=0xDEADBEEF, wstrb=4'hF -> awaddr=0x10000008, wdata=0xDEADBEEF seen, resp_valid 4 cycles after accept, resp_err=0.
- Write with awready delayed 3 cycles and wready immediate, then the reverse -> wvalid drops after 1 cycle, awvalid is held stable until accepted, exactly one B handshake, single resp_valid.
- Read 0x4 with arready delay 2, rvalid delay 5, rdata=0x12345678, rresp=2'b10 -> resp_rdata=0x12345678, resp_err=1, req_ready=0 until completion.
- TIMEOUT=16, read with no rvalid -> resp_valid and resp_err=1 exactly 16 cycles after the AR handshake. A late rvalid at cycle 30 is consumed with no second resp_valid. req_ready returns high the cycle after.
- Assert rst=0 asynchronously mid-WADDR (awvalid=1) -> awvalid, wvalid and resp_valid are 0 immediately without a clock edge. After release, state=IDLE and req_ready=1.
- Back-to-back: a read completes and a write is presented in the same resp_valid cycle -> write accepted that cycle, no idle bubble beyond the IDLE cycle, both responses in order.
